handshake_ctrl_merge_rr: RTL and testbench

- Round-robin control merge that shares one constant/control consumer between NUM_INPUTS requesting control channels.
- Each granted control token is registered into a one-slot output buffer.
- The buffered token is emitted through an eager two-way fork:
  - a dataless token on outs, feeding the ctrl channel of a handshake constant;
  - the winning input number on index, feeding the select of a downstream handshake mux.
- Sits between the basic-block control network and the constant/mux pair of the elastic datapath.

---
 rtl/handshake_ctrl_merge_rr_pkg.sv | 10 +
 rtl/handshake_rr_pick.sv | 29 ++
 rtl/handshake_ctrl_merge_rr.sv | 69 ++++++
 tb/tb_handshake_ctrl_merge_rr.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/handshake_ctrl_merge_rr_pkg.sv
// handshake_ctrl_merge_rr_pkg: shared types for the round-robin control merge slot
package handshake_ctrl_merge_rr_pkg;
  typedef struct packed {
    logic full;
    logic sent_out;
    logic sent_idx;
  } slot_t;
  localparam slot_t SLOT_EMPTY = '{full: 1'b0, sent_out: 1'b0, sent_idx: 1'b0};
  localparam slot_t SLOT_FRESH = '{full: 1'b1, sent_out: 1'b0, sent_idx: 1'b0};
endpackage

// File: rtl/handshake_rr_pick.sv
// handshake_rr_pick: combinational round-robin pick of the first request at or after ptr
module handshake_rr_pick #(
  parameter int NUM_INPUTS  = 2,
  parameter int INDEX_WIDTH = 1
) (
  input  logic [NUM_INPUTS-1:0]  req,
  input  logic [INDEX_WIDTH-1:0] ptr,
  output logic [INDEX_WIDTH-1:0] grant_idx,
  output logic                   any
);
  logic [NUM_INPUTS-1:0]  ge_ptr;
  logic [NUM_INPUTS-1:0]  masked;
  logic [NUM_INPUTS-1:0]  sel;
  logic [NUM_INPUTS-1:0]  low;
  logic [INDEX_WIDTH-1:0] enc [NUM_INPUTS+1];
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_mask
    assign ge_ptr[i] = INDEX_WIDTH'(i) >= ptr;
  end
  assign masked = req & ge_ptr;
  // requests at or above ptr win; otherwise wrap around to the lowest request
  assign sel = |masked ? masked : req;
  assign low = sel & (~sel + 1'b1);
  assign enc[0] = '0;
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_enc
    assign enc[i+1] = enc[i] | (low[i] ? INDEX_WIDTH'(i) : '0);
  end
  assign grant_idx = enc[NUM_INPUTS];
  assign any       = |req;
endmodule

// File: rtl/handshake_ctrl_merge_rr.sv
// handshake_ctrl_merge_rr: round-robin control merge into a one-slot buffer with eager outs/index fork
module handshake_ctrl_merge_rr
  import handshake_ctrl_merge_rr_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int INDEX_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_INPUTS-1:0]  ins_valid,
  output logic [NUM_INPUTS-1:0]  ins_ready,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   index_valid,
  input  logic                   index_ready
);
  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(NUM_INPUTS - 1);
  slot_t                  slot_q, slot_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [INDEX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [INDEX_WIDTH-1:0] winner;
  logic                   any, done_out, done_idx, drain, can_accept, accept;
  handshake_rr_pick #(
    .NUM_INPUTS (NUM_INPUTS),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_pick (
    .req      (ins_valid),
    .ptr      (rr_ptr_q),
    .grant_idx(winner),
    .any      (any)
  );
  assign outs_valid  = slot_q.full & ~slot_q.sent_out;
  assign index_valid = slot_q.full & ~slot_q.sent_idx;
  assign index       = idx_q;
  assign done_out    = slot_q.sent_out | (outs_valid & outs_ready);
  assign done_idx    = slot_q.sent_idx | (index_valid & index_ready);
  assign drain       = slot_q.full & done_out & done_idx;
  // draining and refilling in the same cycle sustains one token per cycle
  assign can_accept  = ~slot_q.full | drain;
  assign accept      = can_accept & any & ~rst;
  assign ins_ready   = accept ? NUM_INPUTS'(1) << winner : '0;
  always_comb begin
    slot_d   = slot_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      slot_d   = SLOT_FRESH;
      idx_d    = winner;
      rr_ptr_d = (winner == LAST) ? '0 : winner + 1'b1;
    end else if (drain) begin
      slot_d = SLOT_EMPTY;
    end else begin
      slot_d.sent_out = done_out;
      slot_d.sent_idx = done_idx;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= SLOT_EMPTY;
      idx_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      slot_q   <= slot_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_handshake_ctrl_merge_rr.sv
// tb_handshake_ctrl_merge_rr: directed vector table plus random token scoreboard for the rr control merge
module tb_handshake_ctrl_merge_rr;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ins_valid = '0;
  logic [3:0] ins_ready;
  logic       outs_valid, index_valid;
  logic       outs_ready = 1'b0;
  logic       index_ready = 1'b0;
  logic [1:0] index;
  logic [0:0] v1 = '0;
  logic [0:0] r1;
  logic       ov1, iv1;
  logic       or1 = 1'b0;
  logic       ir1 = 1'b0;
  logic [0:0] idx1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  handshake_ctrl_merge_rr #(.NUM_INPUTS(4), .INDEX_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs_valid(outs_valid), .outs_ready(outs_ready), .index(index),
    .index_valid(index_valid), .index_ready(index_ready)
  );

  handshake_ctrl_merge_rr #(.NUM_INPUTS(1), .INDEX_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .ins_valid(v1), .ins_ready(r1),
    .outs_valid(ov1), .outs_ready(or1), .index(idx1),
    .index_valid(iv1), .index_ready(ir1)
  );

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       o_rdy;
    logic       i_rdy;
    logic [3:0] e_ready;
    logic       e_ov;
    logic       e_iv;
    logic [1:0] e_idx;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic o, input logic i,
                     input logic [3:0] er, input logic eo, input logic ei, input logic [1:0] ex);
    vec_t t;
    t.rst = r; t.v = v; t.o_rdy = o; t.i_rdy = i;
    t.e_ready = er; t.e_ov = eo; t.e_iv = ei; t.e_idx = ex;
    tbl.push_back(t);
  endtask

  int acc[4];
  int hist[4];
  int nout, total;
  int exp_q[$];
  logic p_ov, p_or, p_iv, p_ir;
  logic [1:0] p_idx;
  logic [3:0] held;

  initial begin
    // reset and single request
    add(1, 4'b1111, 1, 1, 4'b0000, 0, 0, 2'd0);
    add(0, 4'b0010, 1, 1, 4'b0010, 0, 0, 2'd0);
    add(0, 4'b0000, 1, 1, 4'b0000, 1, 1, 2'd1);
    add(0, 4'b0000, 1, 1, 4'b0000, 0, 0, 2'd1);
    // contention: rotation starts after the last winner
    add(0, 4'b1111, 1, 1, 4'b0100, 0, 0, 2'd1);
    add(0, 4'b1111, 1, 1, 4'b1000, 1, 1, 2'd2);
    add(0, 4'b1111, 1, 1, 4'b0001, 1, 1, 2'd3);
    add(0, 4'b1111, 1, 1, 4'b0010, 1, 1, 2'd0);
    add(0, 4'b1111, 1, 1, 4'b0100, 1, 1, 2'd1);
    add(0, 4'b0000, 1, 1, 4'b0000, 1, 1, 2'd2);
    add(0, 4'b0000, 1, 1, 4'b0000, 0, 0, 2'd2);
    // split fork: outs fires, index stalls three cycles
    add(0, 4'b0100, 1, 0, 4'b0100, 0, 0, 2'd2);
    add(0, 4'b0001, 1, 0, 4'b0000, 1, 1, 2'd2);
    add(0, 4'b0001, 1, 0, 4'b0000, 0, 1, 2'd2);
    add(0, 4'b0001, 1, 0, 4'b0000, 0, 1, 2'd2);
    add(0, 4'b0001, 1, 1, 4'b0001, 0, 1, 2'd2);
    // full backpressure then release
    add(0, 4'b0011, 0, 0, 4'b0000, 1, 1, 2'd0);
    add(0, 4'b0011, 0, 0, 4'b0000, 1, 1, 2'd0);
    add(0, 4'b0011, 0, 0, 4'b0000, 1, 1, 2'd0);
    add(0, 4'b0011, 0, 0, 4'b0000, 1, 1, 2'd0);
    add(0, 4'b0011, 1, 1, 4'b0010, 1, 1, 2'd0);
    add(0, 4'b0001, 1, 1, 4'b0001, 1, 1, 2'd1);
    add(0, 4'b0100, 1, 1, 4'b0100, 1, 1, 2'd0);
    // mid-operation reset with outs already delivered
    add(0, 4'b0000, 1, 0, 4'b0000, 1, 1, 2'd2);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 2'd2);
    add(1, 4'b1111, 0, 0, 4'b0000, 0, 1, 2'd2);
    add(0, 4'b1111, 1, 1, 4'b0001, 0, 0, 2'd0);
    add(0, 4'b0000, 1, 1, 4'b0000, 1, 1, 2'd0);
    // idle cycles keep priority at input 1
    add(0, 4'b0000, 1, 1, 4'b0000, 0, 0, 2'd0);
    add(0, 4'b0000, 1, 1, 4'b0000, 0, 0, 2'd0);
    add(0, 4'b1111, 1, 1, 4'b0010, 0, 0, 2'd0);

    repeat (2) @(posedge clk);
    foreach (tbl[n]) begin
      @(posedge clk);
      #1;
      rst = tbl[n].rst;
      ins_valid = tbl[n].v;
      outs_ready = tbl[n].o_rdy;
      index_ready = tbl[n].i_rdy;
      @(negedge clk);
      chk($sformatf("row%0d ins_ready", n), 32'(ins_ready), 32'(tbl[n].e_ready));
      chk($sformatf("row%0d outs_valid", n), 32'(outs_valid), 32'(tbl[n].e_ov));
      chk($sformatf("row%0d index_valid", n), 32'(index_valid), 32'(tbl[n].e_iv));
      chk($sformatf("row%0d index", n), 32'(index), 32'(tbl[n].e_idx));
    end

    @(posedge clk);
    #1;
    ins_valid = '0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 4; i++) begin
      acc[i] = 0;
      hist[i] = 0;
    end
    nout = 0;
    total = 0;
    p_ov = 0; p_or = 0; p_iv = 0; p_ir = 0; p_idx = '0;
    held = '0;
    for (int c = 0; c < 10010; c++) begin
      @(posedge clk);
      #1;
      if (c < 10000) begin
        ins_valid = held | 4'($urandom_range(0, 15));
        outs_ready = 1'($urandom_range(0, 1));
        index_ready = 1'($urandom_range(0, 1));
      end else begin
        ins_valid = '0;
        outs_ready = 1'b1;
        index_ready = 1'b1;
      end
      @(negedge clk);
      if ($countones(ins_ready) > 1 || (ins_ready & ~ins_valid) != 0)
        chk("rand ready_onehot", 32'(ins_ready), 32'(ins_ready & ins_valid & -ins_ready));
      if (p_ov && !p_or) chk("rand outs_valid_hold", 32'(outs_valid), 32'd1);
      if (p_iv && !p_ir) begin
        chk("rand index_valid_hold", 32'(index_valid), 32'd1);
        chk("rand index_stable", 32'(index), 32'(p_idx));
      end
      if (outs_valid && outs_ready) nout++;
      if (index_valid && index_ready) begin
        hist[index]++;
        if (exp_q.size() == 0) chk("rand index_unexpected", 32'(index), 32'hFFFF_FFFF);
        else chk("rand index_order", 32'(index), 32'(exp_q.pop_front()));
      end
      for (int i = 0; i < 4; i++)
        if (((ins_ready & ins_valid) >> i) & 4'd1) begin
          acc[i]++;
          total++;
          exp_q.push_back(i);
        end
      held = ins_valid & ~ins_ready;
      p_ov = outs_valid; p_or = outs_ready;
      p_iv = index_valid; p_ir = index_ready; p_idx = index;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("rand accepts_vs_index[%0d]", i), 32'(hist[i]), 32'(acc[i]));
    chk("rand outs_count", 32'(nout), 32'(total));
    chk("rand tokens_left", 32'(exp_q.size()), 32'd0);

    // single-input instance: always grants input 0, one token per cycle
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      v1 = 1'b1;
      or1 = 1'b1;
      ir1 = 1'b1;
      @(negedge clk);
      chk($sformatf("n1 ins_ready c%0d", k), 32'(r1), 32'd1);
      chk($sformatf("n1 outs_valid c%0d", k), 32'(ov1), 32'(k > 0));
      chk($sformatf("n1 index c%0d", k), 32'(idx1), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
